// File: rtl/pid_ctrl_if.sv
// Bundles the PID controller's sampled inputs and registered drive outputs.
// No latency of its own; it only carries wires.
// No backpressure: inputs are sampled every clk and outputs are always valid.
interface pid_ctrl_if #(
  parameter int ERR_W = 13,
  parameter int OUT_W = 12
);
  logic signed [ERR_W-1:0] error;
  logic                    not_pedaling;
  logic [3:0]              kp;
  logic                    aw_en;
  logic [OUT_W-1:0]        drv_mag;
  logic                    sat_hi;
  logic                    tick;

  modport master (
    output error, not_pedaling, kp, aw_en,
    input  drv_mag, sat_hi, tick
  );

  modport slave (
    input  error, not_pedaling, kp, aw_en,
    output drv_mag, sat_hi, tick
  );
endinterface

// File: rtl/pid_ctrl.sv
// Decimated-integrator PID: per-clk P and D terms, plus an integrator and error history that update only on tick.
// Latency: drv_mag/sat_hi follow error/kp/integ by one clk; tick is combinational from the counter.
// No backpressure: error is sampled every clk and the drive output is always valid.
module pid_ctrl #(
  parameter int ERR_W    = 13,
  parameter int OUT_W    = 12,
  parameter int INT_W    = 18,
  parameter int D_DEPTH  = 3,
  parameter int D_SAT_W  = 9,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,  // active-high asynchronous reset despite the name
  pid_ctrl_if.slave   bus
);

  localparam int CNT_W  = 20;
  localparam int DIFF_W = ERR_W + 1;
  localparam int PROD_W = ERR_W + 5;
  // Wide enough for p_term + i_term + d_term with margin, never less than OUT_W+6.
  localparam int PID_W  = ((OUT_W + 3 > PROD_W) ? OUT_W + 3 : PROD_W) + 3;

  localparam logic signed [INT_W:0]    INT_MAX = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] D_MAX   = {{(DIFF_W-D_SAT_W+1){1'b0}}, {(D_SAT_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] D_MIN   = {{(DIFF_W-D_SAT_W+1){1'b1}}, {(D_SAT_W-1){1'b0}}};
  localparam logic signed [PID_W-1:0]  OUT_MAX = {{(PID_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [CNT_W-1:0]        cnt_q;
  logic                    tick_w;
  logic signed [ERR_W-1:0] err;
  logic signed [INT_W-1:0] err_x;
  logic signed [INT_W:0]   sum;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic                    aw_hold;
  logic signed [ERR_W-1:0] hist_q [D_DEPTH];
  logic signed [DIFF_W-1:0] d_diff, d_sat;
  logic signed [PROD_W-1:0] prod;
  logic signed [PID_W-1:0]  p_term, i_term, d_term, pid;
  logic [OUT_W-1:0]        drv_q, drv_d;
  logic                    sat_q, sat_d;

  assign err   = bus.error;
  assign err_x = INT_W'(err);

  // Tick fires on the last count of each period and is held low while in reset.
  assign tick_w = !rst_n && ((FAST_SIM != 1'b0) ? (&cnt_q[14:0]) : (&cnt_q));

  // Free-running decimation counter; reset restarts the period from zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) cnt_q <= '0;
    else       cnt_q <= cnt_q + 1'b1;
  end

  // Freeze only while pushing further into a high clamp; decision uses last cycle's sat flag.
  assign aw_hold = bus.aw_en && sat_q && !err[ERR_W-1] && (err != '0);
  assign sum     = (INT_W+1)'(integ_q) + (INT_W+1)'(err_x);

  // Integrator next state: clear, hold, or add-and-clamp to [0, INT_MAX].
  always_comb begin
    integ_d = integ_q;
    if (tick_w) begin
      if (bus.not_pedaling) begin
        integ_d = '0;
      end else if (!aw_hold) begin
        if (sum[INT_W])          integ_d = '0;
        else if (sum > INT_MAX)  integ_d = INT_MAX[INT_W-1:0];
        else                     integ_d = sum[INT_W-1:0];
      end
    end
  end

  // Integrator register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) integ_q <= '0;
    else       integ_q <= integ_d;
  end

  // Error history for the derivative, advanced once per tick.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
    end else if (tick_w) begin
      hist_q[0] <= err;
      for (int i = 1; i < D_DEPTH; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign d_diff = DIFF_W'(err) - DIFF_W'(hist_q[D_DEPTH-1]);

  // Derivative difference clamp.
  always_comb begin
    d_sat = d_diff;
    if (d_diff > D_MAX)      d_sat = D_MAX;
    else if (d_diff < D_MIN) d_sat = D_MIN;
  end

  // kp is unsigned quarter-units; the arithmetic shift floors toward minus infinity.
  assign prod   = PROD_W'(err) * PROD_W'($signed({1'b0, bus.kp}));
  assign p_term = PID_W'(prod >>> 2);
  assign i_term = PID_W'({1'b0, integ_q[INT_W-2 -: OUT_W]});
  assign d_term = PID_W'(d_sat) <<< 1;
  assign pid    = p_term + i_term + d_term;

  // Output clamp to the unsigned drive range, flagging a high clamp.
  always_comb begin
    drv_d = pid[OUT_W-1:0];
    sat_d = 1'b0;
    if (pid[PID_W-1]) begin
      drv_d = '0;
    end else if (pid > OUT_MAX) begin
      drv_d = '1;
      sat_d = 1'b1;
    end
  end

  // Registered drive outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      drv_q <= '0;
      sat_q <= 1'b0;
    end else begin
      drv_q <= drv_d;
      sat_q <= sat_d;
    end
  end

  assign bus.drv_mag = drv_q;
  assign bus.sat_hi  = sat_q;
  assign bus.tick    = tick_w;

endmodule

// File: tb/tb_pid_ctrl.sv
// Bench for pid_ctrl: three instances share error/kp but differ in aw_en/not_pedaling at the second tick.
// INT_W=13 makes i_term equal to the integrator so its value shows directly on drv_mag.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_pid_ctrl;

  localparam int D_DEPTH = 3;
  localparam int INT_W   = 13;
  localparam int OUT_W   = 12;
  localparam int IMAX    = (1 << (INT_W - 1)) - 1;
  localparam int I_SHIFT = INT_W - 1 - OUT_W;
  localparam int OMAX    = (1 << OUT_W) - 1;
  localparam int DMAX    = 255;
  localparam int DMIN    = -256;
  localparam int PERIOD  = 32768;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int       s_err = 0;
  int       s_kp  = 0;
  bit [2:0] s_aw  = '0;
  bit [2:0] s_np  = '0;
  bit       run_chk = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  pid_ctrl_if u_if0 ();
  pid_ctrl_if u_if1 ();
  pid_ctrl_if u_if2 ();

  assign u_if0.error = s_err[12:0];
  assign u_if1.error = s_err[12:0];
  assign u_if2.error = s_err[12:0];
  assign u_if0.kp = s_kp[3:0];
  assign u_if1.kp = s_kp[3:0];
  assign u_if2.kp = s_kp[3:0];
  assign u_if0.aw_en = s_aw[0];
  assign u_if1.aw_en = s_aw[1];
  assign u_if2.aw_en = s_aw[2];
  assign u_if0.not_pedaling = s_np[0];
  assign u_if1.not_pedaling = s_np[1];
  assign u_if2.not_pedaling = s_np[2];

  pid_ctrl #(.INT_W(INT_W), .FAST_SIM(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
  pid_ctrl #(.INT_W(INT_W), .FAST_SIM(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
  pid_ctrl #(.INT_W(INT_W), .FAST_SIM(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));

  logic [11:0] o_drv [3];
  logic [2:0]  o_sat;
  logic [2:0]  o_tick;
  assign o_drv[0] = u_if0.drv_mag;
  assign o_drv[1] = u_if1.drv_mag;
  assign o_drv[2] = u_if2.drv_mag;
  assign o_sat  = {u_if2.sat_hi, u_if1.sat_hi, u_if0.sat_hi};
  assign o_tick = {u_if2.tick, u_if1.tick, u_if0.tick};

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_cnt = 0;
  int m_integ [3];
  int m_hist  [3][D_DEPTH];
  int m_drv   [3];
  int m_sat   [3];

  function automatic int f_pid(input int e, input int k, input int ig, input int old);
    int prod, p, dd;
    prod = e * k;
    if (prod >= 0) p = prod / 4;
    else           p = -((-prod + 3) / 4);
    dd = e - old;
    if (dd > DMAX) dd = DMAX;
    if (dd < DMIN) dd = DMIN;
    return p + (ig >> I_SHIFT) + 2 * dd;
  endfunction

  function automatic int f_drv(input int pid);
    if (pid < 0)    return 0;
    if (pid > OMAX) return OMAX;
    return pid;
  endfunction

  function automatic int f_integ(input int ig, input int e, input bit np, input bit aw, input int sat);
    int s;
    if (np) return 0;
    if (aw && sat == 1 && e > 0) return ig;
    s = ig + e;
    if (s < 0)    return 0;
    if (s > IMAX) return IMAX;
    return s;
  endfunction

  function automatic bit f_tick(input int cnt);
    return (cnt % PERIOD) == PERIOD - 1;
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_cnt <= 0;
      for (int i = 0; i < 3; i++) begin
        m_integ[i] <= 0;
        m_drv[i]   <= 0;
        m_sat[i]   <= 0;
        for (int j = 0; j < D_DEPTH; j++) m_hist[i][j] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (f_tick(m_cnt)) begin
          m_integ[i]   <= f_integ(m_integ[i], s_err, s_np[i], s_aw[i], m_sat[i]);
          m_hist[i][0] <= s_err;
          for (int j = 1; j < D_DEPTH; j++) m_hist[i][j] <= m_hist[i][j-1];
        end
        m_drv[i] <= f_drv(f_pid(s_err, s_kp, m_integ[i], m_hist[i][D_DEPTH-1]));
        m_sat[i] <= (f_pid(s_err, s_kp, m_integ[i], m_hist[i][D_DEPTH-1]) > OMAX) ? 1 : 0;
      end
      m_cnt <= (m_cnt + 1) % (1 << 20);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_chk && !rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check("drv", i, int'(o_drv[i]), m_drv[i]);
        check("sat", i, int'(o_sat[i]), m_sat[i]);
        check("tick", i, int'(o_tick[i]), f_tick(m_cnt) ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input int e, input int k, input bit [2:0] aw, input bit [2:0] np);
    s_err = e;
    s_kp  = k;
    s_aw  = aw;
    s_np  = np;
  endtask

  task automatic drive_rand();
    if ($urandom_range(0, 3) == 0) s_err = int'($urandom_range(0, 8191)) - 4096;
    else                           s_err = int'($urandom_range(0, 1200)) - 600;
    s_kp = int'($urandom_range(0, 15));
    s_aw = 3'($urandom_range(0, 7));
    s_np = 3'($urandom_range(0, 7));
  endtask

  initial begin
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("por_drv", i, int'(o_drv[i]), 0);
      check("por_tick", i, int'(o_tick[i]), 0);
    end
    rst_n   = 1'b0;
    run_chk = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      drive_rand();
      @(negedge clk);
    end

    // Negative step with empty history: derivative clamps, drive floors at zero.
    set_in(-500, 4, 3'b000, 3'b000);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("step_neg_drv", i, int'(o_drv[i]), 0);
      check("step_neg_sat", i, int'(o_sat[i]), 0);
    end

    set_in(100, 4, 3'b000, 3'b000);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check("e100_drv", i, int'(o_drv[i]), 300);

    // Mid-period reset: outputs clear without a clock edge.
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("arst_drv", i, int'(o_drv[i]), 0);
      check("arst_sat", i, int'(o_sat[i]), 0);
      check("arst_tick", i, int'(o_tick[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    for (int cyc = 1; cyc <= 65700; cyc++) begin
      @(negedge clk);
      if (cyc == 32766) check("tick_early", 0, int'(o_tick[0]), 0);
      if (cyc == 32767) for (int i = 0; i < 3; i++) check("tick_first", i, int'(o_tick[i]), 1);
      if (cyc == 32769) for (int i = 0; i < 3; i++) check("after_tick1_drv", i, int'(o_drv[i]), 400);
      if (cyc == 40002) for (int i = 0; i < 3; i++) check("floor_p_drv", i, int'(o_drv[i]), 97);
      if (cyc == 65535) begin
        for (int i = 0; i < 3; i++) begin
          check("tick_second", i, int'(o_tick[i]), 1);
          check("pre_tick2_sat", i, int'(o_sat[i]), 1);
        end
      end
      if (cyc == 65537) begin
        check("clamp_integ_drv", 0, int'(o_drv[0]), 4095);
        check("clamp_integ_sat", 0, int'(o_sat[0]), 0);
        check("aw_hold_drv", 1, int'(o_drv[1]), 100);
        check("np_clear_drv", 2, int'(o_drv[2]), 0);
      end

      if (cyc < 32700)                      drive_rand();
      else if (cyc < 32769)                 set_in(100, 4, 3'b000, 3'b000);
      else if (cyc == 40000 || cyc == 40001) set_in(-1, 1, 3'b000, 3'b000);
      else if (cyc < 65000)                 drive_rand();
      else if (cyc < 65536)                 set_in(4095, 4, 3'b110, 3'b100);
      else if (cyc == 65536)                set_in(0, 0, 3'b000, 3'b000);
      else                                  drive_rand();
    end

    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_ctrl.md
PID_CTRL -- requirements
Module: pid_ctrl

Interface
REQ-001 Parameter ERR_W, default 13: signed error width.
REQ-002 Parameter OUT_W, default 12: unsigned drive magnitude width.
REQ-003 Parameter INT_W, default 18: signed integrator width.
REQ-004 Parameter D_DEPTH, default 3: error-history depth for the derivative, legal range 1..8.
REQ-005 Parameter D_SAT_W, default 9: signed saturation width of the derivative difference.
REQ-006 Parameter FAST_SIM, default 0: 1 selects a 15-bit decimation period, 0 selects a 20-bit period.
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-high reset; 1 = reset asserted.
REQ-009 error  input  ERR_W  signed speed error, sampled every clk.
REQ-010 not_pedaling  input  1  1 = clear integrator on the next tick.
REQ-011 kp  input  4  unsigned proportional gain, units of 1/4 (kp=4 is unity).
REQ-012 aw_en  input  1  1 = anti-windup freeze enabled.
REQ-013 drv_mag  output  OUT_W  registered unsigned drive magnitude.
REQ-014 sat_hi  output  1  registered; 1 when the current drv_mag was clamped high.
REQ-015 tick  output  1  one-cycle pulse marking a decimation update.

Function
REQ-016 A 20-bit free-running counter shall increment every clk and wrap from all-ones to 0.
REQ-017 tick shall be 1 when counter bits [14:0] are all ones if FAST_SIM=1, else when all 20 bits are all ones (period 32768 or 1048576 clks).
REQ-018 err_x shall be error sign-extended to INT_W bits.
REQ-019 On tick with not_pedaling=1, integ shall load 0, regardless of other inputs.
REQ-020 On tick with not_pedaling=0, sum = integ + err_x; integ shall load 0 if sum<0, 2^(INT_W-1)-1 if sum exceeds it, else sum.
REQ-021 Anti-windup: on tick with aw_en=1, sat_hi=1 and error>0, integ shall hold (not_pedaling=1 still clears).
REQ-022 integ shall hold between ticks.
REQ-023 i_term = integ[INT_W-2 : INT_W-1-OUT_W], zero-extended (defaults: bits [16:5]).
REQ-024 A D_DEPTH-stage shift register of error shall shift on tick only; stage 0 loads the current error.
REQ-025 d_diff = error - oldest stage, computed at ERR_W+1 bits with no overflow.
REQ-026 d_diff shall saturate to [-2^(D_SAT_W-1), 2^(D_SAT_W-1)-1] (defaults -256..255); d_term = saturated value x2.
REQ-027 p_term = (error x kp) arithmetically shifted right by 2, rounding toward minus infinity (error=-1, kp=1 gives -1).
REQ-028 pid = p_term + i_term + d_term, computed in a signed width of at least OUT_W+6 bits so no intermediate overflow occurs.
REQ-029 If pid<0, the next drv_mag shall be 0 and the next sat_hi 0.
REQ-030 If pid>2^OUT_W-1, the next drv_mag shall be all ones and the next sat_hi 1.
REQ-031 Otherwise the next drv_mag = pid[OUT_W-1:0] and the next sat_hi 0.
REQ-032 Latency: drv_mag and sat_hi shall reflect error/kp/integ one clk after they change; no other pipeline stages.
REQ-033 tick shall be asserted combinationally in the same cycle the integrator and history update.
REQ-034 The anti-windup decision shall use sat_hi as registered before the tick edge.

Reset
REQ-035 While rst_n=1: counter, integ, all history stages, drv_mag and sat_hi shall be 0 immediately, without waiting for a clk edge.
REQ-036 tick shall be 0 during reset.
REQ-037 Reset mid-period shall restart the decimation count from 0 after release.
REQ-038 The first tick after release shall occur 32767 clks later with FAST_SIM=1.

Verification
REQ-039 FAST_SIM=1, kp=4, error=100, not_pedaling=0 -> drv_mag=100+2*100=300 after 1 clk; after the first tick, integ=100.
REQ-040 error=+4095 (max) held, aw_en=0 -> integ climbs and clamps at 131071; i_term=4095; drv_mag=4095 with sat_hi=1.
REQ-041 Same as REQ-040 with aw_en=1 -> integ stops increasing on the first tick after sat_hi=1 and never reaches 131071.
REQ-042 Step error 0 -> -500, kp=4 -> d_diff saturates to -256 and d_term=-512; pid<0 gives drv_mag=0 until the history flushes after D_DEPTH ticks.
REQ-043 integ nonzero, not_pedaling=1 at a tick with aw_en=1 and sat_hi=1 -> integ=0 on that tick.
REQ-044 Assert rst_n mid-period with drv_mag=300 -> drv_mag, integ and history read 0 before the next clk edge; first tick comes 32767 clks after release.
